// File: rtl/psu_scan_ctrl.sv
// ============================================================================
// psu_scan_ctrl : slides a serial bit stream through a WIN_W-bit window,
//                 samples an external matcher once the window is full, and
//                 counts and locates matches per frame.
// Revision      : 1.0
// ============================================================================
`default_nettype none

module psu_scan_ctrl #(
  parameter int WIN_W = 19,
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             bit_valid,
  input  logic             bit_data,
  output logic             bit_ready,
  output logic [WIN_W-1:0] m_win,
  input  logic             match_in,
  output logic             match_pulse,
  output logic [LEN_W-1:0] match_pos,
  output logic [LEN_W-1:0] match_cnt,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_CHECK = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W:0] WIN_THR = (LEN_W+1)'(WIN_W);

  state_t           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_idx_q, bit_idx_d;
  logic [LEN_W-1:0] match_cnt_q, match_cnt_d;
  logic [LEN_W-1:0] match_pos_q, match_pos_d;
  logic [WIN_W-1:0] m_win_q, m_win_d;
  logic             bit_ready_q, bit_ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [LEN_W-1:0] idx_inc;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    bit_idx_d   = bit_idx_q;
    match_cnt_d = match_cnt_q;
    match_pos_d = match_pos_q;
    m_win_d     = m_win_q;
    idx_inc     = bit_idx_q + LEN_W'(1);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          len_d       = frame_len;
          m_win_d     = '0;
          bit_idx_d   = '0;
          match_cnt_d = '0;
          match_pos_d = '0;
          state_d     = (frame_len == '0) ? S_DONE : S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (bit_valid) begin
          m_win_d   = {m_win_q[WIN_W-2:0], bit_data};
          bit_idx_d = idx_inc;
          // Once the window is full every new bit gets one matcher look.
          if ({1'b0, idx_inc} >= WIN_THR) begin
            state_d = S_CHECK;
          end else if (idx_inc == len_q) begin
            state_d = S_DONE;
          end
        end
      end
      S_CHECK: begin
        if (match_in) begin
          if (match_cnt_q != '1) begin
            match_cnt_d = match_cnt_q + LEN_W'(1);
          end
          match_pos_d = bit_idx_q - LEN_W'(1);
        end
        state_d = (bit_idx_q == len_q) ? S_DONE : S_SHIFT;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    bit_ready_d = (state_d == S_SHIFT);
    busy_d      = (state_d != S_IDLE);
    done_d      = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      bit_idx_q   <= '0;
      match_cnt_q <= '0;
      match_pos_q <= '0;
      m_win_q     <= '0;
      bit_ready_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      bit_idx_q   <= bit_idx_d;
      match_cnt_q <= match_cnt_d;
      match_pos_q <= match_pos_d;
      m_win_q     <= m_win_d;
      bit_ready_q <= bit_ready_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // The matcher answers combinationally for the current window, so the pulse
  // has to be taken from it directly during CHECK.
  assign match_pulse = (state_q == S_CHECK) && match_in;
  assign bit_ready   = bit_ready_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign m_win       = m_win_q;
  assign match_cnt   = match_cnt_q;
  assign match_pos   = match_pos_q;

endmodule

`default_nettype wire

// File: tb/tb_psu_scan_ctrl.sv
// ============================================================================
// tb_psu_scan_ctrl : scoreboard bench for psu_scan_ctrl with a modelled matcher.
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_psu_scan_ctrl;

  localparam int WIN_W = 19;
  localparam int LEN_W = 16;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [LEN_W-1:0] frame_len;
  logic             bit_valid;
  logic             bit_data;
  logic             bit_ready;
  logic [WIN_W-1:0] m_win;
  logic             match_in;
  logic             match_pulse;
  logic [LEN_W-1:0] match_pos;
  logic [LEN_W-1:0] match_cnt;
  logic             busy;
  logic             done;

  logic [WIN_W-1:0] target;
  logic [WIN_W-1:0] model_win;
  logic             force_all;
  bit               stream [0:63];

  int exp_pos_q [$];
  int exp_cnt_q [$];
  int n_vec;
  int n_err;

  logic pend;
  int   pend_val;
  logic done_chk;
  int   tmp;

  psu_scan_ctrl #(.WIN_W(WIN_W), .LEN_W(LEN_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .frame_len   (frame_len),
    .bit_valid   (bit_valid),
    .bit_data    (bit_data),
    .bit_ready   (bit_ready),
    .m_win       (m_win),
    .match_in    (match_in),
    .match_pulse (match_pulse),
    .match_pos   (match_pos),
    .match_cnt   (match_cnt),
    .busy        (busy),
    .done        (done)
  );

  assign match_in = force_all ? 1'b1 : (m_win == target);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Precompute the expected matches (and final count) from the stream.
  task automatic prep(input int len, input int upto, input bit push_done);
    logic [WIN_W-1:0] w;
    int m;
    w = '0;
    m = 0;
    for (int i = 0; i < upto; i++) begin
      w = {w[WIN_W-2:0], stream[i]};
      if (i + 1 >= WIN_W && (force_all || w == target)) begin
        exp_pos_q.push_back(i);
        m++;
      end
    end
    if (push_done && len >= 0) exp_cnt_q.push_back(m);
    model_win = w;
  endtask

  task automatic start_frame(input int len);
    @(negedge clk);
    start     = 1'b1;
    frame_len = LEN_W'(len);
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic drive_bits(input int n, input bit rnd);
    int i;
    int g;
    i = 0;
    g = 0;
    while (i < n && g < 4000) begin
      bit_data  = stream[i];
      bit_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (bit_valid && bit_ready) i++;
      g++;
      @(negedge clk);
    end
    bit_valid = 1'b0;
    if (i < n) check("drive_timeout", 32'(i), 32'(n));
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (busy && g < 200) begin
      @(negedge clk);
      g++;
    end
    check("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic run_frame(input int len, input bit rnd);
    prep(len, len, 1'b1);
    start_frame(len);
    drive_bits(len, rnd);
    wait_idle();
    check("m_win_hold", 32'(m_win), 32'(model_win));
  endtask

  // Output monitor: pops expectations as the DUT reports matches and frame ends.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend     <= 1'b0;
      done_chk <= 1'b0;
    end else begin
      if (pend) check("match_pos", 32'(match_pos), 32'(pend_val));
      pend <= 1'b0;
      if (done_chk) begin
        check("done_width", 32'(done), 32'd0);
        check("busy_after_done", 32'(busy), 32'd0);
      end
      if (match_pulse) begin
        check("pulse_with_done", 32'(done), 32'd0);
        check("ready_in_check", 32'(bit_ready), 32'd0);
        if (exp_pos_q.size() == 0) begin
          check("unexpected_pulse", 32'd1, 32'd0);
        end else begin
          tmp = exp_pos_q.pop_front();
          pend_val <= tmp;
          pend     <= 1'b1;
        end
      end
      if (done) begin
        if (exp_cnt_q.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          tmp = exp_cnt_q.pop_front();
          check("match_cnt_at_done", 32'(match_cnt), 32'(tmp));
        end
      end
      done_chk <= done;
    end
  end

  initial begin
    n_vec     = 0;
    n_err     = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    frame_len = '0;
    bit_valid = 1'b0;
    bit_data  = 1'b0;
    force_all = 1'b0;
    target    = '0;
    model_win = '0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_ready", 32'(bit_ready), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cnt", 32'(match_cnt), 32'd0);
    check("rst_win", 32'(m_win), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Single full-window frame that matches exactly once.
    target = 19'b0000001010101111100;
    for (int i = 0; i < WIN_W; i++) stream[i] = target[WIN_W-1-i];
    run_frame(19, 1'b0);
    check("t1_pos", 32'(match_pos), 32'd18);
    check("t1_cnt", 32'(match_cnt), 32'd1);

    // Match on the first window only; the second CHECK must stay quiet.
    target = 19'b0010010011011101000;
    for (int i = 0; i < WIN_W; i++) stream[i] = target[WIN_W-1-i];
    stream[19] = 1'b1;
    run_frame(20, 1'b0);
    check("t2_pos", 32'(match_pos), 32'd18);
    check("t2_cnt", 32'(match_cnt), 32'd1);

    // Empty frame: one DONE cycle, never ready.
    exp_cnt_q.push_back(0);
    start_frame(0);
    check("t3_busy", 32'(busy), 32'd1);
    check("t3_done", 32'(done), 32'd1);
    check("t3_ready", 32'(bit_ready), 32'd0);
    @(negedge clk);
    check("t3_busy_end", 32'(busy), 32'd0);
    check("t3_ready_end", 32'(bit_ready), 32'd0);

    // Short frame with the matcher stuck high: no CHECK may occur.
    force_all = 1'b1;
    for (int i = 0; i < 10; i++) stream[i] = 1'($urandom_range(0, 1));
    run_frame(10, 1'b0);
    check("t4_cnt", 32'(match_cnt), 32'd0);

    // Long frame with a stalling source and every window matching.
    for (int i = 0; i < 40; i++) stream[i] = 1'($urandom_range(0, 1));
    run_frame(40, 1'b1);
    check("t5_cnt", 32'(match_cnt), 32'd22);
    check("t5_pos", 32'(match_pos), 32'd39);

    // Abort a frame with reset after 25 bits.
    for (int i = 0; i < 40; i++) stream[i] = 1'($urandom_range(0, 1));
    prep(40, 25, 1'b0);
    start_frame(40);
    drive_bits(25, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_ready", 32'(bit_ready), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_pulse", 32'(match_pulse), 32'd0);
    check("abort_cnt", 32'(match_cnt), 32'd0);
    check("abort_pos", 32'(match_pos), 32'd0);
    check("abort_win", 32'(m_win), 32'd0);
    check("abort_pending", 32'(exp_pos_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check("abort_stay_idle", 32'(busy), 32'd0);
    run_frame(40, 1'b0);
    check("t6_cnt", 32'(match_cnt), 32'd22);

    repeat (2) @(negedge clk);
    check("pos_queue_empty", 32'(exp_pos_q.size()), 32'd0);
    check("cnt_queue_empty", 32'(exp_cnt_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
